// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo-N counter: FSM state encoding and direction values.
package mod_counter_pkg;

   localparam logic [0:0] ST_COUNT  = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_prescaler.sv
// Prescale counter: emits one tick every presc+1 enabled cycles, restartable by clr/load.
module count_prescaler #(
   parameter int PRESC_WIDTH = 4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   restart,
   input  logic [PRESC_WIDTH-1:0] presc,
   output logic                   tick
);

   logic [PRESC_WIDTH-1:0] cnt_reg;

   // A restart wins over a tick so the next interval always begins from the restarting edge.
   assign tick = ena && !restart && (cnt_reg == presc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (restart || tick) begin
         cnt_reg <= '0;
      end else if (ena) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with clear, clamped load, one-shot halt and registered wrap pulse.
// Optional prescaler built when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int MODULUS     = 256,
   parameter int PRESC_WIDTH = 4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   clr,
   input  logic                   load,
   input  logic [WIDTH-1:0]       din,
   input  logic                   up_dn,
   input  logic                   one_shot,
`ifdef MOD_COUNTER_PRESCALE_EN
   input  logic [PRESC_WIDTH-1:0] presc,
`endif
   output logic [WIDTH-1:0]       q,
   output logic                   wrap,
   output logic                   done
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2^WIDTH still compares correctly against din.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS out of range");
   end
   if (PRESC_WIDTH < 1) begin : g_bad_presc
      $error("mod_counter: PRESC_WIDTH must be at least 1");
   end

   logic [WIDTH-1:0] q_reg, q_next;
   logic [0:0]       state_reg, state_next;
   logic             wrap_reg, wrap_next;
   logic             done_reg, done_next;
   logic             step_en;
   logic             step;
   logic             at_term;
   logic [WIDTH-1:0] load_val;

   assign step_en = ena && (state_reg == ST_COUNT);

`ifdef MOD_COUNTER_PRESCALE_EN
   count_prescaler #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_presc (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (step_en),
      .restart (clr || load),
      .presc   (presc),
      .tick    (step)
   );
`else
   assign step = step_en;
`endif

   assign at_term  = (up_dn == DIR_UP) ? (q_reg == MAX_VAL) : (q_reg == '0);
   assign load_val = ({1'b0, din} >= MOD_EXT) ? MAX_VAL : din;

   always_comb begin
      q_next     = q_reg;
      state_next = state_reg;
      wrap_next  = 1'b0;
      done_next  = done_reg;
      if (clr) begin
         q_next     = '0;
         state_next = ST_COUNT;
         done_next  = 1'b0;
      end else if (load) begin
         q_next     = load_val;
         state_next = ST_COUNT;
         done_next  = 1'b0;
      end else if (step) begin
         if (!at_term) begin
            q_next = (up_dn == DIR_UP) ? q_reg + 1'b1 : q_reg - 1'b1;
         end else if (one_shot) begin
            state_next = ST_HALTED;
            done_next  = 1'b1;
         end else begin
            q_next    = (up_dn == DIR_UP) ? '0 : MAX_VAL;
            wrap_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg     <= '0;
         state_reg <= ST_COUNT;
         wrap_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         q_reg     <= q_next;
         state_reg <= state_next;
         wrap_reg  <= wrap_next;
         done_reg  <= done_next;
      end
   end

   assign q    = q_reg;
   assign wrap = wrap_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter with WIDTH=4, MODULUS=10.
module tb_mod_counter;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       clr;
   logic       load;
   logic [3:0] din;
   logic       up_dn;
   logic       one_shot;
`ifdef MOD_COUNTER_PRESCALE_EN
   logic [3:0] presc;
`endif
   logic [3:0] q;
   logic       wrap;
   logic       done;

   int checks = 0;
   int errors = 0;

   mod_counter #(
      .WIDTH       (4),
      .MODULUS     (10),
      .PRESC_WIDTH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .clr      (clr),
      .load     (load),
      .din      (din),
      .up_dn    (up_dn),
      .one_shot (one_shot),
`ifdef MOD_COUNTER_PRESCALE_EN
      .presc    (presc),
`endif
      .q        (q),
      .wrap     (wrap),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic idle_inputs();
      ena = 0; clr = 0; load = 0; din = 0; up_dn = 1; one_shot = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #3;
      checks++;
      if (q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      $display("reset: q=%0d wrap=%b done=%b", q, wrap, done);
      #9;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_count_up();
      idle_inputs();
      pulse_reset();
      ena = 1; up_dn = 1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         checks++;
         if (q !== 4'(i % 10)) begin errors++; $display("FAIL up_q[%0d] got %0d want %0d", i, q, i % 10); end
         checks++;
         if (wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap[%0d] got %b want %b", i, wrap, (i == 10)); end
         $display("up step %0d: q=%0d wrap=%b", i, q, wrap);
      end
      ena = 0;
   endtask

   task automatic test_count_down();
      logic [3:0] exp_q [4] = '{4'd9, 4'd8, 4'd7, 4'd6};
      idle_inputs();
      pulse_reset();
      ena = 1; up_dn = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (q !== exp_q[i]) begin errors++; $display("FAIL down_q[%0d] got %0d want %0d", i, q, exp_q[i]); end
         checks++;
         if (wrap !== (i == 0)) begin errors++; $display("FAIL down_wrap[%0d] got %b want %b", i, wrap, (i == 0)); end
         $display("down step %0d: q=%0d wrap=%b", i, q, wrap);
      end
      ena = 0;
   endtask

   task automatic test_clr_load();
      // q is 6 from the down-count test.
      clr = 1; load = 1; din = 4'd7; ena = 1;
      tick();
      checks++;
      if (q !== 4'd0) begin errors++; $display("FAIL clr_priority_q got %0d want 0", q); end
      $display("clr+load+ena: q=%0d", q);
      clr = 0; load = 1; din = 4'd12; ena = 0;
      tick();
      checks++;
      if (q !== 4'd9) begin errors++; $display("FAIL load_clamp_q got %0d want 9", q); end
      $display("load 12: q=%0d", q);
      load = 1; din = 4'd4; ena = 1; up_dn = 1;
      tick();
      checks++;
      if (q !== 4'd4) begin errors++; $display("FAIL load_ena_q got %0d want 4", q); end
      $display("load 4 with ena: q=%0d", q);
      // Terminal up value with clr+ena: clr wins, no wrap.
      load = 1; din = 4'd9; ena = 0;
      tick();
      load = 0; clr = 1; ena = 1;
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin
         errors++; $display("FAIL clr_at_term got q=%0d wrap=%b want q=0 wrap=0", q, wrap);
      end
      $display("clr at terminal: q=%0d wrap=%b", q, wrap);
      idle_inputs();
   endtask

   task automatic test_one_shot();
      idle_inputs();
      one_shot = 1; up_dn = 1; load = 1; din = 4'd8;
      tick();
      load = 0; ena = 1;
      tick();
      checks++;
      if (q !== 4'd9 || done !== 1'b0) begin
         errors++; $display("FAIL os_reach got q=%0d done=%b want q=9 done=0", q, done);
      end
      $display("one-shot reach: q=%0d done=%b", q, done);
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin up_dn = 0; one_shot = 0; end
         tick();
         checks++;
         if (q !== 4'd9 || done !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL os_hold[%0d] got q=%0d done=%b wrap=%b want q=9 done=1 wrap=0", i, q, done, wrap);
         end
         $display("one-shot hold %0d: q=%0d done=%b wrap=%b", i, q, done, wrap);
      end
      up_dn = 1; one_shot = 1; ena = 0; load = 1; din = 4'd3;
      tick();
      checks++;
      if (q !== 4'd3 || done !== 1'b0) begin
         errors++; $display("FAIL os_reload got q=%0d done=%b want q=3 done=0", q, done);
      end
      $display("one-shot reload: q=%0d done=%b", q, done);
      load = 0; ena = 1;
      tick();
      checks++;
      if (q !== 4'd4) begin errors++; $display("FAIL os_resume got %0d want 4", q); end
      $display("one-shot resume: q=%0d", q);
      // Down-direction halt at 0.
      ena = 0; load = 1; din = 4'd1; up_dn = 0;
      tick();
      load = 0; ena = 1;
      tick();
      tick();
      checks++;
      if (q !== 4'd0 || done !== 1'b1 || wrap !== 1'b0) begin
         errors++; $display("FAIL os_down got q=%0d done=%b wrap=%b want q=0 done=1 wrap=0", q, done, wrap);
      end
      $display("one-shot down halt: q=%0d done=%b wrap=%b", q, done, wrap);
      idle_inputs();
   endtask

   task automatic test_async_reset();
      idle_inputs();
      pulse_reset();
      ena = 1; up_dn = 1;
      repeat (5) tick();
      checks++;
      if (q !== 4'd5) begin errors++; $display("FAIL ar_pre got %0d want 5", q); end
      rst_n = 1'b0;
      #2;
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL ar_mid got q=%0d wrap=%b done=%b want 0 0 0", q, wrap, done);
      end
      $display("async reset: q=%0d wrap=%b done=%b", q, wrap, done);
      rst_n = 1'b1;
      tick();
      checks++;
      if (q !== 4'd1) begin errors++; $display("FAIL ar_restart got %0d want 1", q); end
      $display("after reset release: q=%0d", q);
      // Pending wrap pulse is cleared by reset.
      repeat (9) tick();
      rst_n = 1'b0;
      #2;
      checks++;
      if (wrap !== 1'b0 || q !== 4'd0) begin
         errors++; $display("FAIL ar_wrap got q=%0d wrap=%b want q=0 wrap=0", q, wrap);
      end
      rst_n = 1'b1;
      ena = 0;
      tick();
      checks++;
      if (wrap !== 1'b0 || q !== 4'd0) begin
         errors++; $display("FAIL ar_no_residual got q=%0d wrap=%b want q=0 wrap=0", q, wrap);
      end
      $display("reset during wrap: q=%0d wrap=%b", q, wrap);
      idle_inputs();
   endtask

`ifdef MOD_COUNTER_PRESCALE_EN
   task automatic test_prescale();
      logic [3:0] exp_q [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
      idle_inputs();
      presc = 4'd2;
      pulse_reset();
      ena = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (q !== exp_q[i]) begin errors++; $display("FAIL presc_q[%0d] got %0d want %0d", i, q, exp_q[i]); end
         $display("presc cycle %0d: q=%0d", i, q);
      end
      tick();
      clr = 1;
      tick();
      clr = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== ((i == 2) ? 4'd1 : 4'd0)) begin
            errors++; $display("FAIL presc_clr[%0d] got %0d want %0d", i, q, (i == 2) ? 1 : 0);
         end
         $display("presc after clr %0d: q=%0d", i, q);
      end
      presc = 4'd0;
      idle_inputs();
   endtask
`endif

   initial begin
`ifdef MOD_COUNTER_PRESCALE_EN
      presc = 4'd0;
`endif
      test_reset();
      test_count_up();
      test_count_down();
      test_clr_load();
      test_one_shot();
      test_async_reset();
`ifdef MOD_COUNTER_PRESCALE_EN
      test_prescale();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter with synchronous clear, parallel load, one-shot mode and a registered wrap pulse. It generalises the plain free-running binary counter used across the LED designs into a general timing and sequencing source. Typical uses are LED pattern sequencers, timebase dividers and bounded event counters. The counter sits directly behind the clock domain's enable strobes and drives pattern/PWM logic.

## Interface
- WIDTH, 8, counter width in bits
- MODULUS, 256, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH
- PRESC_WIDTH, 4, prescaler select width; used only when MOD_COUNTER_PRESCALE_EN is defined

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  count enable; one step per enabled cycle (per prescaled tick when prescaler is built)
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load from din
- din  in  WIDTH  load value
- up_dn  in  1  direction: 1 = up, 0 = down
- one_shot  in  1  1 = stop at terminal instead of wrapping
- presc  in  PRESC_WIDTH  prescale select; port present only with MOD_COUNTER_PRESCALE_EN
- q  out  WIDTH  counter value, registered
- wrap  out  1  one-cycle pulse: a wrap occurred on the previous edge, registered
- done  out  1  high while halted in one-shot mode, registered

## Operation
- Priority per edge, highest first: clr > load > count step.
  - clr: q=0, state COUNT, done=0.
  - load: q=din; if din ≥ MODULUS, q=MODULUS-1. State COUNT, done=0.
- Step condition: state COUNT and ena=1 (and prescaler tick when built).
- Terminal value: MODULUS-1 when up_dn=1; 0 when up_dn=0.
- Step when q is not terminal: q±1 per up_dn.
- Step at terminal, one_shot=0: q wraps (up: to 0; down: to MODULUS-1). wrap=1 for exactly the next cycle.
- Step at terminal, one_shot=1: q holds, done=1, state HALTED, wrap stays 0.
- FSM states:
  - COUNT (reset state): steps as above.
  - HALTED: ignores ena, up_dn and one_shot. Exits only via clr or load, both of which return to COUNT.
- up_dn and one_shot are sampled on every step; a change takes effect on the next step.
- Arithmetic is WIDTH bits. MODULUS-1 is computed as a constant. No overflow past MODULUS-1 is reachable.

## Timing
- All outputs are registered. q updates on the same rising edge that samples clr/load/step. Latency from an input to q is 1 clock.
- wrap is high in the cycle in which q shows the wrapped value. It is never high two consecutive cycles unless wraps occur on consecutive steps.
- done rises together with the halting edge. It falls on the edge that applies clr or load.
- Reset (rst_n low, no clock needed): q=0, wrap=0, done=0, state COUNT, prescaler count 0.
- Reset mid-operation aborts any count, halt or pending wrap. There is no residual pulse after release.
- Simultaneous clr+load+ena: clr wins, and no wrap is generated.
- load+ena: the loaded value is taken, and no step happens that cycle.

## Configuration
- MOD_COUNTER_PRESCALE_EN defined:
  - Adds the presc port and an internal PRESC_WIDTH-bit prescale counter.
  - A step tick fires once every presc+1 enabled cycles, so presc=0 gives a step on every enabled cycle.
  - The prescale counter advances only when ena=1 and state is COUNT.
  - The prescale counter resets to 0 on rst_n, clr, load and on every tick.
- Undefined: no presc port and no prescale logic. Every enabled cycle in COUNT is a step.

## Structure
- mod_counter_pkg holds:
  - state encoding constants ST_COUNT, ST_HALTED
  - direction constants DIR_UP=1, DIR_DOWN=0
- Sub-module count_prescaler implements the prescale counter and tick. It is instantiated only under MOD_COUNTER_PRESCALE_EN and has the same clk/rst_n.
- mod_counter holds the FSM, load clamp, next-value logic and output registers.

## Test plan
- WIDTH=4, MODULUS=10, up_dn=1, ena=1 for 12 cycles from reset -> q=1..9,0,1,2. wrap is high only in the cycle q returns to 0.
- Same configuration, up_dn=0, ena=1 from reset -> q=9 with wrap=1, then 8, 7, …
- clr=1, load=1, din=7 together -> q=0. Then load=1, din=12 -> q=9. Then load=1, ena=1, din=4 -> q=4, with no step.
- one_shot=1, up, load din=8, ena=1 -> q=9, then done=1 and q holds 9 for ≥5 enabled cycles with wrap=0. Then load din=3 -> done=0, q=3, then 4 on the next step.
- Count to q=5, then pulse rst_n low between edges -> q=0, wrap=0, done=0 immediately. After release, counting restarts from 0.
- With MOD_COUNTER_PRESCALE_EN, presc=2, ena=1 -> q increments every 3rd cycle. A clr mid-interval restarts the 3-cycle spacing from that edge.
